serial_byte_tx: RTL and testbench

Upstream serializer for the serial-capture interface stage. Accepts parallel words on a valid/ready handshake, buffers them in a small FIFO, and emits them one bit per `i_clk` cycle, LSB first, on `o_a`. `o_a` drives the capture stage's `i_a` directly. Back-to-back words stream with no gap, and `o_sof` marks bit 0 of every word so the downstream stage can align its bit index.

---
 rtl/serial_pkg.sv | 12 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/serial_byte_tx.sv | 135 +++++++++++++
 tb/tb_serial_byte_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and defaults for the serial transmit/capture pair
package serial_pkg;

  // Word width used by both the serializer and the capture stage.
  localparam int unsigned SERIAL_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // Next-state: write at tail, advance head on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = i_push && !o_full;
    pop_ok   = i_pop && !o_empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; everything clears on reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_byte_tx.sv
// rtl/serial_byte_tx.sv - buffered parallel-to-serial transmitter, LSB first
module serial_byte_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH    = SERIAL_WIDTH,
  parameter int   DEPTH    = 2,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic                       o_a,
  output logic                       o_sof,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(WIDTH - 1);

  tx_state_t        state_q, state_d;
  // sr holds only the bits not yet presented on o_a; bit 0 goes out next.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic             a_q, a_d;
  logic             sof_q, sof_d;
  logic             busy_q, busy_d;
  // Registered copy of "FIFO non-empty": an idle launch is decided from
  // the previous cycle's occupancy, giving a fixed two-edge push-to-bit-0 latency.
  logic             fifo_avail_q, fifo_avail_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load;

  // Ready comes from occupancy only, so a same-cycle pop never reopens a full FIFO.
  assign o_ready   = i_arst_n & ~fifo_full;
  assign fifo_push = i_valid & o_ready;

  assign o_a    = a_q;
  assign o_sof  = sof_q;
  assign o_busy = busy_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_push   (fifo_push),
    .i_pop    (fifo_pop),
    .i_data   (i_data),
    .o_data   (fifo_head),
    .o_count  (o_count),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  // FSM next-state: launch a word, step through its bits, chain or go idle.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bc_d         = bc_q;
    a_d          = a_q;
    sof_d        = sof_q;
    busy_d       = busy_q;
    fifo_avail_d = !fifo_empty;
    fifo_pop     = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (fifo_avail_q && !fifo_empty) begin
          load = 1'b1;
        end else begin
          a_d    = IDLE_BIT;
          sof_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        if (bc_q != BC_LAST) begin
          bc_d  = bc_q + BCW'(1);
          a_d   = sr_q[0];
          sr_d  = sr_q >> 1;
          sof_d = 1'b0;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          a_d     = IDLE_BIT;
          sof_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      a_d      = fifo_head[0];
      sr_d     = fifo_head[WIDTH-1:1];
      sof_d    = 1'b1;
      busy_d   = 1'b1;
      bc_d     = '0;
      state_d  = SHIFT;
    end
  end

  // State, shift register, bit counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bc_q         <= '0;
      a_q          <= IDLE_BIT;
      sof_q        <= 1'b0;
      busy_q       <= 1'b0;
      fifo_avail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bc_q         <= bc_d;
      a_q          <= a_d;
      sof_q        <= sof_d;
      busy_q       <= busy_d;
      fifo_avail_q <= fifo_avail_d;
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// tb/tb_serial_byte_tx.sv - directed self-checking bench for serial_byte_tx
module tb_serial_byte_tx;

  logic       i_clk = 1'b0;
  logic       i_arst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       o_a;
  logic       o_sof;
  logic       o_busy;
  logic [1:0] o_count;

  int errors = 0;
  int checks = 0;

  serial_byte_tx #(
    .WIDTH    (8),
    .DEPTH    (2),
    .IDLE_BIT (1'b0)
  ) dut (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_a      (o_a),
    .o_sof    (o_sof),
    .o_busy   (o_busy),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Capture-stage model: align on o_sof, gather 8 bits LSB first.
  logic [7:0] cap_sr = 8'h00;
  int         cap_idx = 0;
  logic [7:0] rx_q[$];
  int         sof_viol = 0;

  always @(negedge i_clk) begin
    if (!i_arst_n) begin
      cap_idx = 0;
    end else begin
      if (o_sof && !o_busy) sof_viol++;
      if (o_sof) begin
        cap_sr    = 8'h00;
        cap_sr[0] = o_a;
        cap_idx   = 1;
      end else if (cap_idx > 0) begin
        cap_sr[cap_idx] = o_a;
        cap_idx++;
      end
      if (cap_idx == 8) begin
        rx_q.push_back(cap_sr);
        cap_idx = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input string name);
    int t = 0;
    i_data  = d;
    i_valid = 1'b1;
    while (!o_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk({name, "_push_timeout"}, 32'd0, 32'd1);
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int t = 0;
    while (rx_q.size() < n && t < 400) begin
      step();
      t++;
    end
    chk({name, "_rx_timeout"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((o_busy || o_count != 2'd0) && t < 400) begin
      step();
      t++;
    end
    chk({name, "_idle_timeout"}, 32'(t < 400), 32'd1);
    step();
  endtask

  // seq holds the expected o_a stream in time order: seq[7] first, seq[0] last.
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic       sa   [12];
    logic       ssof [12];
    logic       sbusy[12];
    logic [15:0] a16;
    logic [15:0] s16;
    int          nb;
    int          ns;
    int          base;
    int          bad;

    vecs[0] = '{data: 8'hA5, seq: 8'b1010_0101};
    vecs[1] = '{data: 8'h01, seq: 8'b1000_0000};
    vecs[2] = '{data: 8'h12, seq: 8'b0100_1000};
    vecs[3] = '{data: 8'hE0, seq: 8'b0000_0111};
    vecs[4] = '{data: 8'hC3, seq: 8'b1100_0011};

    // Reset values while held in reset
    step();
    step();
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_count", o_count, 2'd0);
    chk("rst_a", o_a, 1'b0);
    chk("rst_sof", o_sof, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    i_arst_n = 1'b1;
    step();
    chk("rel_ready", o_ready, 1'b1);
    chk("rel_count", o_count, 2'd0);

    // Table: single word into an idle block, cycle-exact
    for (int v = 0; v < 5; v++) begin
      wait_idle($sformatf("vec%0d", v));
      push_word(vecs[v].data, $sformatf("vec%0d", v));
      for (int t = 1; t < 12; t++) begin
        step();
        sa[t]    = o_a;
        ssof[t]  = o_sof;
        sbusy[t] = o_busy;
      end
      chk($sformatf("vec%0d_sof_n1", v), ssof[1], 1'b0);
      chk($sformatf("vec%0d_sof_n2", v), ssof[2], 1'b1);
      ns = 0;
      nb = 0;
      for (int t = 1; t < 12; t++) begin
        ns += ssof[t] ? 1 : 0;
        nb += sbusy[t] ? 1 : 0;
      end
      chk($sformatf("vec%0d_sof_count", v), ns, 1);
      chk($sformatf("vec%0d_busy_count", v), nb, 8);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("vec%0d_bit%0d", v, k), sa[2 + k], vecs[v].seq[7 - k]);
      end
      chk($sformatf("vec%0d_idle_after", v), sa[10], 1'b0);
      chk($sformatf("vec%0d_busy_after", v), sbusy[10], 1'b0);
    end

    // Back-to-back: 01 then 80 on consecutive edges
    wait_idle("b2b");
    i_data  = 8'h01;
    i_valid = 1'b1;
    step();
    i_data = 8'h80;
    step();
    i_valid = 1'b0;
    for (int t = 0; t < 16; t++) begin
      step();
      a16[t] = o_a;
      s16[t] = o_sof;
    end
    chk("b2b_bits", a16, 16'h8001);
    chk("b2b_sof", s16, 16'h0101);
    step();
    chk("b2b_busy_end", o_busy, 1'b0);

    // Full FIFO with valid held high
    wait_idle("full");
    base    = rx_q.size();
    i_valid = 1'b1;
    i_data  = 8'h11;
    step();
    i_data = 8'h22;
    step();
    chk("full_count2", o_count, 2'd2);
    chk("full_ready_low", o_ready, 1'b0);
    i_data = 8'h33;
    step();
    chk("full_count_after_pop", o_count, 2'd1);
    chk("full_ready_back", o_ready, 1'b1);
    step();
    i_valid = 1'b0;
    chk("full_count_third", o_count, 2'd2);
    wait_rx(base + 3, "full");
    if (rx_q.size() >= base + 3) begin
      chk("full_w0", rx_q[base], 8'h11);
      chk("full_w1", rx_q[base + 1], 8'h22);
      chk("full_w2", rx_q[base + 2], 8'h33);
    end

    // Push coinciding with a word-boundary pop at occupancy 1
    wait_idle("simul");
    base = rx_q.size();
    push_word(8'h44, "simul_a");
    push_word(8'h55, "simul_b");
    step();
    chk("simul_sof_first", o_sof, 1'b1);
    chk("simul_count_pre", o_count, 2'd1);
    repeat (7) step();
    i_data  = 8'h66;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("simul_count_held", o_count, 2'd1);
    chk("simul_sof_second", o_sof, 1'b1);
    wait_rx(base + 3, "simul");
    if (rx_q.size() >= base + 3) begin
      chk("simul_w0", rx_q[base], 8'h44);
      chk("simul_w1", rx_q[base + 1], 8'h55);
      chk("simul_w2", rx_q[base + 2], 8'h66);
    end
    repeat (12) step();
    chk("simul_no_dup", rx_q.size(), base + 3);

    // End-to-end recovery through the capture model
    wait_idle("e2e");
    base = rx_q.size();
    push_word(8'h3C, "e2e_a");
    push_word(8'hC3, "e2e_b");
    push_word(8'hFF, "e2e_c");
    wait_rx(base + 3, "e2e");
    if (rx_q.size() >= base + 3) begin
      chk("e2e_w0", rx_q[base], 8'h3C);
      chk("e2e_w1", rx_q[base + 1], 8'hC3);
      chk("e2e_w2", rx_q[base + 2], 8'hFF);
    end

    // Reset mid-word with a second word still queued
    wait_idle("mid");
    push_word(8'h5A, "mid_a");
    push_word(8'h6B, "mid_b");
    repeat (3) step();
    chk("mid_busy_before", o_busy, 1'b1);
    chk("mid_count_before", o_count, 2'd1);
    #2;
    i_arst_n = 1'b0;
    #1;
    chk("mid_rst_a", o_a, 1'b0);
    chk("mid_rst_sof", o_sof, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_count", o_count, 2'd0);
    chk("mid_rst_ready", o_ready, 1'b0);
    step();
    i_arst_n = 1'b1;
    base = rx_q.size();
    step();
    chk("mid_rel_ready", o_ready, 1'b1);
    chk("mid_rel_count", o_count, 2'd0);
    bad = 0;
    for (int t = 0; t < 24; t++) begin
      step();
      if (o_a !== 1'b0 || o_busy !== 1'b0 || o_sof !== 1'b0) bad++;
    end
    chk("mid_idle_hold", bad, 0);
    chk("mid_no_words", rx_q.size(), base);

    chk("sof_without_busy", sof_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
